// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_wr_arbiter_pkg: shared types and width helpers for the FIFO write-port arbiter
package fifo_wr_arbiter_pkg;

   typedef enum logic {IDLE, BURST} arb_state_t;

   function automatic int ow_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: cyclic priority encoder, first requester at/after rr_ptr wins
module rr_pick
   import fifo_wr_arbiter_pkg::*;
#(
   parameter int NREQ = 4,
   localparam int OW = ow_of(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [OW-1:0]   rr_ptr,
   output logic [OW-1:0]   idx,
   output logic            found
);

   logic [OW-1:0] j;

   // scan offsets from farthest to nearest so the nearest hit is the last assignment
   always_comb begin
      idx = '0;
      j   = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         j = OW'((int'(rr_ptr) + k) % NREQ);
         if (req[j]) idx = j;
      end
   end

   assign found = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-bounded sharing of the FIFO write port
module fifo_wr_arbiter
   import fifo_wr_arbiter_pkg::*;
#(
   parameter int NREQ     = 4,
   parameter int DATASIZE = 8,
   parameter int MAXBURST = 4,
   localparam int OW = ow_of(NREQ)
) (
   input  logic                     wclk,
   input  logic                     wrst_n,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*DATASIZE-1:0] wdata_in,
   output logic [NREQ-1:0]          ack,
   input  logic                     wfull,
   output logic                     winc,
   output logic [DATASIZE-1:0]      wdata,
   output logic [OW-1:0]            owner,
   output logic                     busy
);

   localparam int BW = $clog2(MAXBURST + 1);

   arb_state_t          state;
   logic [OW-1:0]       rr_ptr;
   logic [OW-1:0]       pick;
   logic [BW-1:0]       beat_cnt;
   logic                found;
   logic                fire;
   logic                last;
   logic [DATASIZE-1:0] slice [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_slice
      assign slice[g] = wdata_in[g*DATASIZE +: DATASIZE];
   end

   rr_pick #(.NREQ(NREQ)) u_pick (
      .req    (req),
      .rr_ptr (rr_ptr),
      .idx    (pick),
      .found  (found)
   );

   // a beat moves only when the owner still requests and the FIFO has room this cycle
   assign fire  = (state == BURST) && req[owner] && !wfull;
   assign last  = beat_cnt == BW'(MAXBURST - 1);
   assign winc  = fire;
   assign ack   = fire ? (NREQ'(1) << owner) : '0;
   assign busy  = state == BURST;
   assign wdata = slice[owner];

   // grant in IDLE, count beats in BURST, rotate the pointer on every release
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         state    <= IDLE;
         owner    <= '0;
         rr_ptr   <= '0;
         beat_cnt <= '0;
      end else if (state == IDLE) begin
         if (found) begin
            owner    <= pick;
            beat_cnt <= '0;
            state    <= BURST;
         end
      end else begin
         if (fire) beat_cnt <= beat_cnt + 1'b1;
         if ((fire && last) || !req[owner]) begin
            state  <= IDLE;
            rr_ptr <= (owner == OW'(NREQ - 1)) ? '0 : owner + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: scoreboard bench with a grant-level reference model
module tb_fifo_wr_arbiter;

   localparam int NREQ  = 4;
   localparam int DS    = 8;
   localparam int MB    = 4;
   localparam int OW    = 2;
   localparam int DEPTH = 4;

   logic               wclk = 0;
   logic               wrst_n = 0;
   logic [NREQ-1:0]    req = '0;
   logic [NREQ*DS-1:0] wdata_in = '0;
   logic               wfull = 0;
   logic [NREQ-1:0]    ack;
   logic               winc;
   logic [DS-1:0]      wdata;
   logic [OW-1:0]      owner;
   logic               busy;

   int checks = 0;
   int passed = 0;

   logic [DS-1:0] tx_q  [NREQ][$];
   logic [DS-1:0] exp_q [NREQ][$];
   int            wlog[$];
   int            fcount = 0;
   bit            gen = 1;
   int            mi;

   int m_busy, m_owner, m_ptr, m_left;

   int              last_winc, last_owner, last_busy;
   logic [NREQ-1:0] just_acked = '0;
   logic [NREQ-1:0] cur_act = '0;
   logic [9:0]      pat = '0;

   always #5 wclk = ~wclk;

   fifo_wr_arbiter #(.NREQ(NREQ), .DATASIZE(DS), .MAXBURST(MB)) dut (
      .wclk     (wclk),
      .wrst_n   (wrst_n),
      .req      (req),
      .wdata_in (wdata_in),
      .ack      (ack),
      .wfull    (wfull),
      .winc     (winc),
      .wdata    (wdata),
      .owner    (owner),
      .busy     (busy)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   function automatic void model_reset();
      m_busy  = 0;
      m_owner = 0;
      m_ptr   = 0;
      m_left  = 0;
   endfunction

   function automatic int pending();
      int n = 0;
      for (int i = 0; i < NREQ; i++) n += tx_q[i].size();
      return n;
   endfunction

   // monitor: every written beat must be the oldest outstanding beat of the acked requester
   always @(negedge wclk) begin
      if (wrst_n && winc) begin
         chk("no_write_when_full", int'(wfull), 0);
         if ($countones(ack) != 1) chk("ack_onehot", $countones(ack), 1);
         else begin
            mi = $clog2(ack);
            wlog.push_back(mi);
            if (exp_q[mi].size() == 0) chk("unexpected_beat", mi, -1);
            else chk("wdata_order", int'(wdata), int'(exp_q[mi].pop_front()));
         end
      end
      if (winc && !wfull) fcount++;
      if (fcount > 0 && $urandom_range(0, 2) == 0) fcount--;
   end

   // one clock of stimulus plus the reference-model comparison; wf: 0/1 forced, 2 = FIFO model
   task automatic cycle(input logic [NREQ-1:0] act, input int wf);
      bit fire, got;
      logic [DS-1:0] d;
      @(posedge wclk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
         if (gen && tx_q[i].size() == 0) begin
            d = DS'($urandom);
            tx_q[i].push_back(d);
            exp_q[i].push_back(d);
         end
         req[i] = act[i] && tx_q[i].size() != 0;
         wdata_in[i*DS +: DS] = (tx_q[i].size() != 0) ? tx_q[i][0] : '0;
      end
      wfull = (wf == 2) ? (fcount >= DEPTH) : (wf == 1);
      @(negedge wclk);
      fire = m_busy != 0 && req[m_owner] && !wfull;
      chk("winc", int'(winc), int'(fire));
      chk("ack", int'(ack), fire ? (1 << m_owner) : 0);
      chk("busy", int'(busy), m_busy);
      chk("owner", int'(owner), m_owner);
      last_winc  = winc;
      last_owner = owner;
      last_busy  = busy;
      if (m_busy == 0) begin
         got = 0;
         for (int k = 0; k < NREQ; k++)
            if (!got && req[(m_ptr + k) % NREQ]) begin
               got     = 1;
               m_owner = (m_ptr + k) % NREQ;
            end
         if (got) begin
            m_busy = 1;
            m_left = MB;
         end
      end else begin
         if (fire) m_left--;
         if (m_left == 0 || !req[m_owner]) begin
            m_busy = 0;
            m_ptr  = (m_owner + 1) % NREQ;
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         just_acked[i] = ack[i];
         if (ack[i]) void'(tx_q[i].pop_front());
      end
   endtask

   // asynchronous reset: outputs must clear before any clock edge
   task automatic reset_pulse();
      @(posedge wclk);
      #1;
      wrst_n = 0;
      req    = '0;
      #1;
      chk("rst_winc", int'(winc), 0);
      chk("rst_ack", int'(ack), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_owner", int'(owner), 0);
      model_reset();
      @(posedge wclk);
      #1;
      wrst_n = 1;
   endtask

   initial begin
      int n0, cnt, guard;
      model_reset();
      #2;
      chk("init_winc", int'(winc), 0);
      chk("init_ack", int'(ack), 0);
      chk("init_busy", int'(busy), 0);
      chk("init_owner", int'(owner), 0);
      @(posedge wclk);
      #1;
      wrst_n = 1;

      // single requester: grant, four beats, idle, re-grant to 0
      repeat (10) begin
         cycle(4'b0001, 0);
         pat = {pat[8:0], last_winc[0]};
      end
      chk("t1_pattern", int'(pat), int'(10'b0111101111));

      // all requesting: bursts of four rotating 0,1,2,3,0
      reset_pulse();
      #1;
      n0 = wlog.size();
      repeat (25) cycle(4'b1111, 0);
      #1;
      chk("t2_writes", wlog.size() - n0, 20);
      for (int k = 0; k < 20; k++)
         if (n0 + k < wlog.size()) chk("t2_order", wlog[n0 + k], (k / 4) % 4);

      // stall on wfull keeps ownership and the remaining beats
      reset_pulse();
      #1;
      n0 = wlog.size();
      cycle(4'b0100, 0);
      cycle(4'b0100, 0);
      repeat (3) begin
         cycle(4'b0100, 1);
         chk("t3_stall_winc", last_winc, 0);
         chk("t3_stall_owner", last_owner, 2);
         chk("t3_stall_busy", last_busy, 1);
      end
      repeat (4) cycle(4'b0100, 0);
      #1;
      cnt = 0;
      for (int k = n0; k < wlog.size(); k++) if (wlog[k] == 2) cnt++;
      chk("t3_total", cnt, 4);

      // owner 1 drops after two beats; pointer moves to 2 so 0011 grants 0
      reset_pulse();
      cycle(4'b0010, 0);
      cycle(4'b0010, 0);
      cycle(4'b0010, 0);
      cycle(4'b0000, 0);
      cycle(4'b0011, 0);
      chk("t4_idle", last_busy, 0);
      cycle(4'b0011, 0);
      chk("t4_owner", last_owner, 0);
      chk("t4_busy", last_busy, 1);

      // reset mid-burst, then a lone request from 3
      reset_pulse();
      cycle(4'b1111, 0);
      cycle(4'b1111, 0);
      cycle(4'b1111, 0);
      chk("t5_busy_before", last_busy, 1);
      reset_pulse();
      cycle(4'b1000, 0);
      cycle(4'b1000, 0);
      chk("t5_owner", last_owner, 3);
      chk("t5_winc", last_winc, 1);

      // random traffic against a FIFO occupancy model
      reset_pulse();
      just_acked = '0;
      repeat (10000) begin
         for (int i = 0; i < NREQ; i++)
            if (!(m_busy != 0 && m_owner == i) || just_acked[i])
               cur_act[i] = $urandom_range(0, 3) != 0;
         cycle(cur_act, 2);
      end

      // drain everything still outstanding; nothing may be lost
      gen   = 0;
      guard = 0;
      while (pending() > 0 && guard < 400) begin
         cycle(4'b1111, 0);
         guard++;
      end
      #1;
      for (int i = 0; i < NREQ; i++) chk("drained", exp_q[i].size(), 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
